uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver (start, 8 data LSB-first, even parity, stop).
//
// The asynchronous line passes through a two-flop synchroniser. Each bit is
// sampled at mid-bit using a cycle counter. The received byte is held in an
// output register with a valid/acknowledge handshake.
//
// Ports:
//   clk_i          system clock
//   n_rst_i        synchronous reset, active high
//   rx_line_i      asynchronous serial input, idles high
//   rd_ack_i       one-cycle pulse: consumer took the byte
//   data_o         last accepted byte
//   data_valid_o   data_o holds an unread byte
//   parity_err_o   parity mismatch for the byte in data_o
//   frame_err_o    stop bit of the byte in data_o was sampled low
//   overrun_o      sticky: a frame completed while data_valid_o=1 and was dropped
//   busy_o         receiver is not idle
module uart_rx #(
    parameter int BIT_CYCLES = 20
) (
    input  logic       clk_i,
    input  logic       n_rst_i,
    input  logic       rx_line_i,
    input  logic       rd_ack_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_MID = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            commit;

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        data_d    = data_q;
        dv_d      = dv_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        commit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // armed stops a line that is held low from retriggering.
                if (!rx_s_q && armed_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;          // false start
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_END) begin
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    commit  = 1'b1;
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_s_q) armed_d = 1'b1;
        if (state_d == S_START && state_q != S_START) armed_d = 1'b0;

        // Clear on state entry and at each bit boundary within DATA.
        if (state_d != state_q || cnt_q == CNT_END) begin
            cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (commit) begin
            if (!dv_q || rd_ack_i) begin
                data_d = shreg_q;
                perr_d = (^shreg_q) ^ par_q;
                ferr_d = ~rx_s_q;
                dv_d   = 1'b1;
                ovr_d  = 1'b0;
            end else begin
                ovr_d  = 1'b1;
            end
        end else if (rd_ack_i) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (n_rst_i) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            par_q     <= 1'b0;
            data_q    <= 8'd0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_line_i;
            rx_s_q    <= rx_meta_q;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table-driven frames, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx;
    localparam int BC = 20;

    logic       clk_i = 1'b0;
    logic       n_rst_i = 1'b1;
    logic       rx_line_i = 1'b1;
    logic       rd_ack_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

    int checks = 0;
    int errors = 0;

    uart_rx #(.BIT_CYCLES(BC)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .rx_line_i(rx_line_i), .rd_ack_i(rd_ack_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        bit         flip;     // send the wrong parity bit
        bit         stop;     // value driven in the stop bit
        bit         ack;      // acknowledge after checking
        logic [7:0] e_data;
        bit         e_pe;
        bit         e_fe;
        bit         e_ov;
    } vec_t;

    vec_t tbl[7];

    // frame-level reference model
    logic [7:0] m_data;
    bit         m_dv, m_pe, m_fe, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input bit dv,
                           input bit pe, input bit fe, input bit ov);
        chk({tag, ".data"}, 32'(data_o), 32'(d));
        chk({tag, ".valid"}, 32'(data_valid_o), 32'(dv));
        chk({tag, ".perr"}, 32'(parity_err_o), 32'(pe));
        chk({tag, ".ferr"}, 32'(frame_err_o), 32'(fe));
        chk({tag, ".ovr"}, 32'(overrun_o), 32'(ov));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_line_i = v;
        idle(n);
    endtask

    task automatic send_head(input logic [7:0] d, input bit flip);
        drive_bit(1'b0, BC);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BC);
        drive_bit((^d) ^ flip, BC);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
        send_head(d, flip);
        drive_bit(stop, BC);
        rx_line_i = 1'b1;
    endtask

    task automatic ack();
        rd_ack_i = 1'b1;
        idle(1);
        rd_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        n_rst_i   = 1'b1;
        rx_line_i = 1'b1;
        idle(3);
        chk_all("reset", 8'h00, 0, 0, 0, 0);
        chk("reset.busy", 32'(busy_o), 0);
        n_rst_i = 1'b0;
        idle(5);
    endtask

    initial begin
        int n;
        logic [7:0] rd;
        bit rflip, rstop, rack;

        tbl[0] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};

        #1;
        do_reset();

        // single frame with start-edge to data_valid latency
        n = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                while (n < 400 && !data_valid_o) begin
                    @(posedge clk_i);
                    #1;
                    n++;
                end
            end
        join
        checks++;
        if (n < 2 + BC/2 + 10*BC || n > 2 + BC/2 + 10*BC + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", n,
                     2 + BC/2 + 10*BC, 2 + BC/2 + 10*BC + 2);
        end
        idle(4);
        chk_all("a5", 8'hA5, 1, 0, 0, 0);
        ack();
        chk_all("a5_ack", 8'hA5, 0, 0, 0, 0);

        // table of frames
        foreach (tbl[i]) begin
            send_frame(tbl[i].d, tbl[i].flip, tbl[i].stop);
            idle(4);
            chk_all($sformatf("tbl%0d", i), tbl[i].e_data, 1, tbl[i].e_pe, tbl[i].e_fe, tbl[i].e_ov);
            if (tbl[i].ack) begin
                ack();
                chk($sformatf("tbl%0d_ack.valid", i), 32'(data_valid_o), 0);
                chk($sformatf("tbl%0d_ack.ovr", i), 32'(overrun_o), 0);
                chk($sformatf("tbl%0d_ack.data", i), 32'(data_o), 32'(tbl[i].e_data));
            end
        end

        // long break after stop: busy holds until line returns high
        send_head(8'h55, 1'b0);
        drive_bit(1'b0, 2*BC);
        chk("break.busy_low", 32'(busy_o), 1);
        drive_bit(1'b0, BC);
        chk("break.busy_still", 32'(busy_o), 1);
        drive_bit(1'b1, 5);
        chk("break.busy_end", 32'(busy_o), 0);
        chk_all("break", 8'h55, 1, 0, 1, 0);
        ack();
        send_frame(8'h12, 1'b0, 1'b1);
        idle(4);
        chk_all("after_break", 8'h12, 1, 0, 0, 0);
        ack();

        // glitch shorter than half a bit
        drive_bit(1'b0, 5);
        chk("glitch.busy_seen", 32'(busy_o), 1);
        drive_bit(1'b1, 30);
        chk("glitch.busy", 32'(busy_o), 0);
        chk("glitch.valid", 32'(data_valid_o), 0);

        // rd_ack in the same cycle as the second frame's commit
        send_frame(8'h11, 1'b0, 1'b1);
        idle(4);
        chk_all("pre_coinc", 8'h11, 1, 0, 0, 0);
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                repeat (2 + BC/2 + 10*BC) @(posedge clk_i);
                #1;
                rd_ack_i = 1'b1;
                idle(1);
                rd_ack_i = 1'b0;
            end
        join
        idle(4);
        chk_all("coinc", 8'h22, 1, 0, 0, 0);

        // reset in the middle of a frame
        drive_bit(1'b0, BC);
        drive_bit(1'b0, BC);
        drive_bit(1'b0, BC);
        n_rst_i   = 1'b1;
        rx_line_i = 1'b1;
        idle(1);
        chk_all("midreset", 8'h00, 0, 0, 0, 0);
        chk("midreset.busy", 32'(busy_o), 0);
        idle(2);
        n_rst_i = 1'b0;
        idle(10);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(4);
        chk_all("post_reset", 8'h0F, 1, 0, 0, 0);
        ack();

        // back-to-back frames, zero idle gap
        fork
            begin
                send_frame(8'h81, 1'b0, 1'b1);
                send_frame(8'h7E, 1'b0, 1'b1);
            end
            begin
                repeat (216) @(posedge clk_i);
                #1;
                chk_all("b2b_first", 8'h81, 1, 0, 0, 0);
                ack();
                chk("b2b_first_ack.valid", 32'(data_valid_o), 0);
            end
        join
        idle(4);
        chk_all("b2b_second", 8'h7E, 1, 0, 0, 0);
        ack();

        // randomized frames against the reference model
        do_reset();
        m_data = 8'h00; m_dv = 0; m_pe = 0; m_fe = 0; m_ov = 0;
        for (int k = 0; k < 16; k++) begin
            rd    = 8'($urandom);
            rflip = ($urandom_range(3) == 0);
            rstop = ($urandom_range(7) != 0);
            rack  = ($urandom_range(1) == 1);
            send_frame(rd, rflip, rstop);
            idle(4);
            if (!m_dv) begin
                m_data = rd; m_pe = rflip; m_fe = !rstop; m_dv = 1;
            end else begin
                m_ov = 1;
            end
            chk_all($sformatf("rnd%0d", k), m_data, m_dv, m_pe, m_fe, m_ov);
            if (rack) begin
                ack();
                m_dv = 0; m_ov = 0;
                chk_all($sformatf("rnd%0d_ack", k), m_data, m_dv, m_pe, m_fe, m_ov);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
